// File: rtl/mdu_pkg.sv
//============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the MIPS32 multiply/divide unit:
//               op encodings, FSM state type and counter width helper.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mdu_pkg;

  // Op encodings driven by decode; 3'b11x is a no-op.
  localparam logic [2:0] MDU_OP_MULT  = 3'b000;
  localparam logic [2:0] MDU_OP_MULTU = 3'b001;
  localparam logic [2:0] MDU_OP_DIV   = 3'b010;
  localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
  localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
  localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // Iteration counter width: enough to count 0 .. width-1.
  function automatic int mdu_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
//============================================================================
// Module      : mul_div_unit_if
// Description : Request/result bundle between decode/EX and the mul/div unit.
//   start, op, src_a, src_b, flush : request side (master drives)
//   busy, done, hi, lo             : status and HI/LO (slave drives)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/mdu_div_step.sv
//============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit (quo MSB) into the partial remainder, trial
//               subtracts the divisor and shifts the quotient bit into quo.
//   rem, quo, divisor : current partial remainder / dividend-quotient / divisor
//   rem_nxt, quo_nxt  : values after this step
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;
  logic           unused_diff_msb;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});
  assign diff    = shifted - {1'b0, divisor};

  // When the subtract fits, the result is below the divisor so its MSB is 0.
  assign unused_diff_msb = diff[WIDTH];

  assign rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], fits};

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
//============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle MIPS32 multiply/divide unit owning HI/LO.
//               MULT/MULTU: shift-add, DIV/DIVU: restoring, WIDTH iterations
//               plus one sign-fix cycle. MTHI/MTLO write in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   md       : slave side of mul_div_unit_if (start/op/src_a/src_b/flush in,
//              busy/done/hi/lo out)
// Config      : MDU_FAST_MUL_EN - single-cycle multiply (divide unchanged)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input  logic         clk,
  input  logic         rst,
  mul_div_unit_if.slave md
);

  localparam int             CNT_W     = mdu_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MDU_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;     // product high half / partial remainder
  logic [WIDTH-1:0] shf;     // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] opnd;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             a_neg, b_neg, is_div, done_q;

  logic             busy, accept, signed_op, is_mul_op, is_div_op;
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy      = (state != ST_IDLE);
  assign accept    = md.start & ~busy & ~md.flush;
  assign is_mul_op = (md.op == MDU_OP_MULT) || (md.op == MDU_OP_MULTU);
  assign is_div_op = (md.op == MDU_OP_DIV)  || (md.op == MDU_OP_DIVU);
  assign signed_op = (md.op == MDU_OP_MULT) || (md.op == MDU_OP_DIV);
  assign a_sgn     = signed_op & md.src_a[WIDTH-1];
  assign b_sgn     = signed_op & md.src_b[WIDTH-1];
  assign mag_a     = a_sgn ? -md.src_a : md.src_a;
  assign mag_b     = b_sgn ? -md.src_b : md.src_b;

`ifdef MDU_FAST_MUL_EN
  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both flavours.
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{a_sgn}}, md.src_a};
  assign ext_b     = {{WIDTH{b_sgn}}, md.src_b};
  assign fast_prod = ext_a * ext_b;
`endif

  // Shift-add: add multiplicand when the current multiplier LSB is set.
  assign mul_sum = {1'b0, acc} + (shf[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc),
    .quo     (shf),
    .divisor (opnd),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sign fix. Division by zero leaves rem == |dividend|, so rem_fix already
  // reproduces the latched dividend; only the quotient must be forced.
  assign prod_fix = (a_neg ^ b_neg) ? -{acc, shf} : {acc, shf};
  assign rem_fix  = a_neg ? -acc : acc;
  assign quo_fix  = (opnd == '0) ? {WIDTH{1'b1}} :
                    ((a_neg ^ b_neg) ? -shf : shf);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_op) begin
            state_nxt = ST_DIV;
          end else if (is_mul_op && !FAST_MUL) begin
            state_nxt = ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt == LAST_ITER) begin
          state_nxt = ST_FIX;
        end
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (md.flush) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      shf    <= '0;
      opnd   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      is_div <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= HILO_RESET;
      lo_q   <= HILO_RESET;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            a_neg  <= a_sgn;
            b_neg  <= b_sgn;
            is_div <= is_div_op;
            shf    <= is_div_op ? mag_a : mag_b;
            opnd   <= is_div_op ? mag_b : mag_a;
            case (md.op)
              MDU_OP_MTHI: begin
                hi_q   <= md.src_a;
                done_q <= 1'b1;
              end
              MDU_OP_MTLO: begin
                lo_q   <= md.src_a;
                done_q <= 1'b1;
              end
`ifdef MDU_FAST_MUL_EN
              MDU_OP_MULT, MDU_OP_MULTU: begin
                {hi_q, lo_q} <= fast_prod;
                done_q       <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (!md.flush) begin
            {acc, shf} <= {mul_sum, shf[WIDTH-1:1]};
            cnt        <= (cnt == LAST_ITER) ? '0 : cnt + 1'b1;
          end
        end
        ST_DIV: begin
          if (!md.flush) begin
            acc <= rem_nxt;
            shf <= quo_nxt;
            cnt <= (cnt == LAST_ITER) ? '0 : cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!md.flush) begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy = busy;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
//============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit. Expected
//               values are hand-computed constants. Honours MDU_FAST_MUL_EN
//               for multiply timing expectations.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .HILO_RESET(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; inj_kind at sample lat==inj_at: 1 stray start, 2 flush, 3 rst.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int inj_kind,
                        output int lat, output int busy_n, output bit saw_done);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1; busy_n = 0; saw_done = 1'b0;
    while (lat < 200) begin
      if (bus.done) begin saw_done = 1'b1; break; end
      if (!bus.busy) break;
      busy_n++;
      if (lat == inj_at) begin
        case (inj_kind)
          1: begin bus.start = 1'b1; bus.op = MDU_OP_MTHI; bus.src_a = 32'hDEAD_BEEF; end
          2: bus.flush = 1'b1;
          3: rst = 1'b1;
          default: ;
        endcase
      end
      tick();
      lat++;
      bus.start = 1'b0; bus.flush = 1'b0; rst = 1'b0;
    end
    checks++;
    if (lat >= 200) begin errors++; $display("FAIL timeout: op %0d ran %0d cycles, limit 200", op, lat); end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 3'b110; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
  endtask

  task automatic test_mult();
    int lat, bn; bit sd;
    run_op(MDU_OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, lat, bn, sd);
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mult_latency: got %0d want %0d", lat, MUL_LAT); end
    checks++; if (bn !== MUL_BUSY) begin errors++; $display("FAIL mult_busy: got %0d want %0d", bn, MUL_BUSY); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end

    run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, bn, sd);
    checks++; if (bn !== MUL_BUSY) begin errors++; $display("FAIL multu_busy: got %0d want %0d", bn, MUL_BUSY); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end

    run_op(MDU_OP_MULT, 32'h0000_0007, 32'hFFFF_FFFB, 0, 0, lat, bn, sd);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFDD) begin errors++; $display("FAIL mult_neg: got %h%h want ffffffffffffffdd", bus.hi, bus.lo); end
  endtask

  task automatic test_div();
    int lat, bn; bit sd;
    run_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, lat, bn, sd);
    checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div_latency: got %0d want %0d", lat, DIV_LAT); end
    checks++; if (bn !== DIV_BUSY) begin errors++; $display("FAIL div_busy: got %0d want %0d", bn, DIV_BUSY); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end

    run_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, bn, sd);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end

    run_op(MDU_OP_DIVU, 32'd100, 32'd7, 0, 0, lat, bn, sd);
    checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: got %h/%h want 00000002/0000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_div_zero();
    int lat, bn; bit sd;
    run_op(MDU_OP_DIVU, 32'h0000_1234, 32'h0, 5, 1, lat, bn, sd);
    checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL divz_latency: got %0d want %0d", lat, DIV_LAT); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL divz_hi: got %h want 00001234", bus.hi); end

    run_op(MDU_OP_DIV, 32'hFFFF_FFF0, 32'h0, 0, 0, lat, bn, sd);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFF0_FFFF_FFFF) begin errors++; $display("FAIL divz_signed: got %h/%h want fffffff0/ffffffff", bus.hi, bus.lo); end
  endtask

  task automatic test_flush();
    int lat, bn; bit sd;
    run_op(MDU_OP_MTHI, 32'hA5A5_A5A5, 32'h0, 0, 0, lat, bn, sd);
    checks++; if (bus.hi !== 32'hA5A5_A5A5 || lat !== 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mthi: got hi %h lat %0d want a5a5a5a5 lat 1", bus.hi, lat); end
    run_op(MDU_OP_MTLO, 32'h5A5A_5A5A, 32'h0, 0, 0, lat, bn, sd);
    checks++; if (bus.lo !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mtlo: got %h want 5a5a5a5a", bus.lo); end
    tick();

    run_op(MDU_OP_DIVU, 32'd100, 32'd7, 10, 2, lat, bn, sd);
    checks++; if (lat !== 11 || sd !== 1'b0) begin errors++; $display("FAIL flush_stop: got lat %0d done %b want lat 11 done 0", lat, sd); end
    checks++; if ({bus.hi, bus.lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin errors++; $display("FAIL flush_hilo: got %h/%h want a5a5a5a5/5a5a5a5a", bus.hi, bus.lo); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_quiet: got done %b busy %b want 0 0", bus.done, bus.busy); end

    run_op(MDU_OP_MTLO, 32'h1, 32'h0, 0, 0, lat, bn, sd);
    checks++; if (bus.lo !== 32'h1 || lat !== 1 || sd !== 1'b1) begin errors++; $display("FAIL mtlo_after_flush: got lo %h lat %0d want 00000001 lat 1", bus.lo, lat); end
    tick();

    // flush wins over a start in the same cycle
    bus.start = 1'b1; bus.op = MDU_OP_MTHI; bus.src_a = 32'h1111_1111; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5_A5A5 || bus.done !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got hi %h done %b want a5a5a5a5 0", bus.hi, bus.done); end
  endtask

  task automatic test_noop();
    int lat, bn; bit sd;
    run_op(3'b111, 32'hFFFF_0000, 32'h0, 0, 0, lat, bn, sd);
    checks++; if (sd !== 1'b0 || bn !== 0 || bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'h1) begin errors++; $display("FAIL noop: got done %b busy %0d hi %h lo %h want 0 0 a5a5a5a5 00000001", sd, bn, bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit sd;
    run_op(MDU_OP_DIVU, 32'd100, 32'd7, 0, 0, lat, bn, sd);
    run_op(MDU_OP_MULTU, 32'd3, 32'd5, 0, 0, lat, bn, sd);
    checks++; if (lat !== MUL_LAT || {bus.hi, bus.lo} !== 64'd15) begin errors++; $display("FAIL back_to_back: got lat %0d %h/%h want lat %0d 00000000/0000000f", lat, bus.hi, bus.lo, MUL_LAT); end
  endtask

  task automatic test_reset_mid();
    int lat, bn; bit sd;
`ifdef MDU_FAST_MUL_EN
    run_op(MDU_OP_DIVU, 32'h0000_1234, 32'h10, 5, 3, lat, bn, sd);
`else
    run_op(MDU_OP_MULT, 32'h0000_1234, 32'h10, 5, 3, lat, bn, sd);
`endif
    checks++; if (sd !== 1'b0 || lat !== 6) begin errors++; $display("FAIL rst_mid_stop: got done %b lat %0d want 0 6", sd, lat); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got hi %h lo %h busy %b done %b want 0 0 0 0", bus.hi, bus.lo, bus.busy, bus.done); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet: got done %b busy %b want 0 0", bus.done, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_noop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
